rx_serial: RTL and testbench

//  Serial receiver: the downstream peer of the serial transmitter on the link. Recovers
//  8-bit frames from DATA_IN: start bit, D7..D0 (MSB first), optional parity, then 1 or 2 stop bits.

---
 rtl/rx_serial.sv | 190 +++++++++++++++++++
 tb/tb_rx_serial.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/rx_serial.sv
// Serial frame receiver: start bit, D7..D0 MSB first, optional parity, one or two stop bits.
// One received byte is held behind a valid/ready handshake; RTS advertises room for the next.
module rx_serial #(
  parameter logic [7:0]  MODOS   = 8'b10110101,
  parameter logic [15:0] DIV_OVR = 16'd0
) (
  input  logic       i_clock,
  input  logic       i_reset,
  input  logic       i_data_in,
  input  logic       i_rx_ready,
  output logic [7:0] o_rx_data,
  output logic       o_rx_valid,
  output logic       o_parity_err,
  output logic       o_frame_err,
  output logic       o_overrun,
  output logic       o_rts
);

  localparam logic [15:0] BAUD_DIV = (MODOS[7:6] == 2'b00) ? 16'd10416 :
                                     (MODOS[7:6] == 2'b01) ? 16'd5208  :
                                     (MODOS[7:6] == 2'b10) ? 16'd2604  :
                                                             16'd868;
  localparam logic [15:0] DIV  = (DIV_OVR != 16'd0) ? DIV_OVR : BAUD_DIV;
  // Computed in 17 bits so a divisor of 16'hFFFF does not wrap to zero.
  localparam logic [16:0] DIV_PLUS1 = {1'b0, DIV} + 17'd1;
  localparam logic [15:0] HALF = DIV_PLUS1[16:1];

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_PARITY = 3'd3;
  localparam logic [2:0] S_STOP1  = 3'd4;
  localparam logic [2:0] S_STOP2  = 3'd5;

  logic        r_sync1;
  logic        r_sync2;
  logic        r_syncDly;
  logic [2:0]  r_state;
  logic [15:0] r_cnt;
  logic [2:0]  r_bitIdx;
  logic [7:0]  r_shift;
  logic        r_perr;
  logic        r_ferr;
  logic [7:0]  r_data;
  logic        r_valid;
  logic        r_perrOut;
  logic        r_ferrOut;
  logic        r_overrun;

  logic w_fallEdge;
  logic w_bit;
  logic w_tick;
  logic w_inStop;
  logic w_complete;
  logic w_stopErr;
  logic w_frameErrFinal;
  logic w_accept;
  logic w_load;
  logic w_parityCalc;

  // Reset value of 1 matches an idle line, so leaving reset never looks like a start edge.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_sync1   <= 1'b1;
      r_sync2   <= 1'b1;
      r_syncDly <= 1'b1;
    end else begin
      r_sync1   <= i_data_in;
      r_sync2   <= r_sync1;
      r_syncDly <= r_sync2;
    end
  end

  assign w_fallEdge = r_syncDly & ~r_sync2;
  assign w_bit      = r_sync2;

  // The start bit is sampled at its midpoint; every later bit one full period after the previous sample.
  assign w_tick = (r_state == S_START) ? (r_cnt == HALF) :
                  ((r_state != S_IDLE) && (r_cnt == DIV));

  assign w_inStop        = (r_state == S_STOP1) || (r_state == S_STOP2);
  assign w_complete      = w_tick && (((r_state == S_STOP1) && MODOS[5]) || (r_state == S_STOP2));
  assign w_stopErr       = w_tick && w_inStop && !w_bit;
  assign w_frameErrFinal = r_ferr | w_stopErr;
  assign w_accept        = r_valid & i_rx_ready;
  assign w_load          = w_complete & (~r_valid | w_accept);
  assign w_parityCalc    = (^{r_shift, w_bit}) ^ MODOS[1];

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_cnt <= 16'd0;
    end else if ((r_state == S_IDLE) || w_tick) begin
      r_cnt <= 16'd0;
    end else begin
      r_cnt <= r_cnt + 16'd1;
    end
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_state  <= S_IDLE;
      r_bitIdx <= 3'd0;
      r_shift  <= 8'd0;
      r_perr   <= 1'b0;
      r_ferr   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_fallEdge) begin
            r_state <= S_START;
            r_perr  <= 1'b0;
            r_ferr  <= 1'b0;
          end
        end
        S_START: begin
          if (w_tick) begin
            if (w_bit) begin
              r_state <= S_IDLE;
            end else begin
              r_state  <= S_DATA;
              r_bitIdx <= 3'd7;
            end
          end
        end
        S_DATA: begin
          if (w_tick) begin
            r_shift <= {r_shift[6:0], w_bit};
            if (r_bitIdx == 3'd0) begin
              r_state <= MODOS[0] ? S_PARITY : S_STOP1;
            end else begin
              r_bitIdx <= r_bitIdx - 3'd1;
            end
          end
        end
        S_PARITY: begin
          if (w_tick) begin
            r_perr  <= w_parityCalc;
            r_state <= S_STOP1;
          end
        end
        S_STOP1: begin
          if (w_tick) begin
            r_ferr  <= w_frameErrFinal;
            r_state <= MODOS[5] ? S_IDLE : S_STOP2;
          end
        end
        S_STOP2: begin
          if (w_tick) begin
            r_ferr  <= w_frameErrFinal;
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // A frame arriving while the previous byte is still held and not being taken is dropped.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_data    <= 8'd0;
      r_valid   <= 1'b0;
      r_perrOut <= 1'b0;
      r_ferrOut <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      if (w_load) begin
        r_data    <= r_shift;
        r_perrOut <= r_perr;
        r_ferrOut <= w_frameErrFinal;
        r_valid   <= 1'b1;
      end else if (w_accept) begin
        r_valid <= 1'b0;
      end
      if (w_accept) begin
        r_overrun <= 1'b0;
      end else if (w_complete && r_valid) begin
        r_overrun <= 1'b1;
      end
    end
  end

  assign o_rx_data    = r_data;
  assign o_rx_valid   = r_valid;
  assign o_parity_err = r_perrOut;
  assign o_frame_err  = r_ferrOut;
  assign o_overrun    = r_overrun;
  assign o_rts        = ~r_valid;

endmodule

// File: tb/tb_rx_serial.sv
// Self-checking bench for rx_serial: directed frames on three mode variants plus a
// randomized run against a byte-level model of the holding register.
module tb_rx_serial;

  localparam int BIT_CLKS = 16;

  logic clock = 1'b0;
  logic reset;
  logic [2:0] lines;
  logic [2:0] ready;
  logic [2:0][7:0] rxData;
  logic [2:0] rxValid, perr, ferr, ovr, rts;

  int checks = 0;
  int errors = 0;

  always #10 clock = ~clock;

  // Instance 0: even parity, one stop. 1: odd parity, one stop. 2: even parity, two stops.
  rx_serial #(.MODOS(8'b10110101), .DIV_OVR(16'd15)) dutA (
    .i_clock(clock), .i_reset(reset), .i_data_in(lines[0]), .i_rx_ready(ready[0]),
    .o_rx_data(rxData[0]), .o_rx_valid(rxValid[0]), .o_parity_err(perr[0]),
    .o_frame_err(ferr[0]), .o_overrun(ovr[0]), .o_rts(rts[0]));

  rx_serial #(.MODOS(8'b10110111), .DIV_OVR(16'd15)) dutB (
    .i_clock(clock), .i_reset(reset), .i_data_in(lines[1]), .i_rx_ready(ready[1]),
    .o_rx_data(rxData[1]), .o_rx_valid(rxValid[1]), .o_parity_err(perr[1]),
    .o_frame_err(ferr[1]), .o_overrun(ovr[1]), .o_rts(rts[1]));

  rx_serial #(.MODOS(8'b10010101), .DIV_OVR(16'd15)) dutC (
    .i_clock(clock), .i_reset(reset), .i_data_in(lines[2]), .i_rx_ready(ready[2]),
    .o_rx_data(rxData[2]), .o_rx_valid(rxValid[2]), .o_parity_err(perr[2]),
    .o_frame_err(ferr[2]), .o_overrun(ovr[2]), .o_rts(rts[2]));

  function automatic logic evenBit(input logic [7:0] d);
    return ($countones(d) % 2) != 0;
  endfunction

  task automatic driveBit(input int w, input logic b);
    lines[w] = b;
    repeat (BIT_CLKS) @(negedge clock);
  endtask

  task automatic sendFrame(input int w, input logic [7:0] d, input logic p,
                           input logic s1, input logic s2);
    driveBit(w, 1'b0);
    for (int i = 7; i >= 0; i--) driveBit(w, d[i]);
    driveBit(w, p);
    driveBit(w, s1);
    if (w == 2) driveBit(w, s2);
    lines[w] = 1'b1;
  endtask

  task automatic pulseReady(input int w);
    ready[w] = 1'b1;
    @(negedge clock);
    ready[w] = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    lines = 3'b111;
    ready = 3'b000;
    repeat (3) @(negedge clock);
    checks++; if (rxValid !== 3'b000) begin errors++; $display("[TB] FAIL reset_valid: got %b expected 000", rxValid); end
    checks++; if (rts !== 3'b111) begin errors++; $display("[TB] FAIL reset_rts: got %b expected 111", rts); end
    checks++; if ({perr, ferr, ovr} !== 9'd0) begin errors++; $display("[TB] FAIL reset_flags: got %b expected 0", {perr, ferr, ovr}); end
    checks++; if (rxData !== 24'd0) begin errors++; $display("[TB] FAIL reset_data: got %h expected 0", rxData); end
    reset = 1'b0;
    repeat (5) @(negedge clock);
  endtask

  task automatic test_basic;
    sendFrame(0, 8'hA5, evenBit(8'hA5), 1'b1, 1'b1);
    checks++; if (rxData[0] !== 8'hA5) begin errors++; $display("[TB] FAIL basic_data: got %h expected a5", rxData[0]); end
    checks++; if (rxValid[0] !== 1'b1) begin errors++; $display("[TB] FAIL basic_valid: got %b expected 1", rxValid[0]); end
    checks++; if ({perr[0], ferr[0]} !== 2'b00) begin errors++; $display("[TB] FAIL basic_errs: got %b expected 00", {perr[0], ferr[0]}); end
    checks++; if (rts[0] !== 1'b0) begin errors++; $display("[TB] FAIL basic_rts: got %b expected 0", rts[0]); end
    pulseReady(0);
    checks++; if (rxValid[0] !== 1'b0) begin errors++; $display("[TB] FAIL basic_accept: got %b expected 0", rxValid[0]); end
  endtask

  task automatic test_parity;
    sendFrame(0, 8'h01, 1'b0, 1'b1, 1'b1);
    checks++; if (rxData[0] !== 8'h01) begin errors++; $display("[TB] FAIL par_even_data: got %h expected 01", rxData[0]); end
    checks++; if (perr[0] !== 1'b1) begin errors++; $display("[TB] FAIL par_even_err: got %b expected 1", perr[0]); end
    pulseReady(0);
    sendFrame(1, 8'h01, 1'b0, 1'b1, 1'b1);
    checks++; if (rxData[1] !== 8'h01) begin errors++; $display("[TB] FAIL par_odd_data: got %h expected 01", rxData[1]); end
    checks++; if (perr[1] !== 1'b0) begin errors++; $display("[TB] FAIL par_odd_err: got %b expected 0", perr[1]); end
    pulseReady(1);
  endtask

  task automatic test_frame_error;
    sendFrame(0, 8'h3C, evenBit(8'h3C), 1'b0, 1'b1);
    lines[0] = 1'b0;
    checks++; if (rxData[0] !== 8'h3C) begin errors++; $display("[TB] FAIL ferr_data: got %h expected 3c", rxData[0]); end
    checks++; if (ferr[0] !== 1'b1) begin errors++; $display("[TB] FAIL ferr_flag: got %b expected 1", ferr[0]); end
    checks++; if (perr[0] !== 1'b0) begin errors++; $display("[TB] FAIL ferr_perr: got %b expected 0", perr[0]); end
    pulseReady(0);
    repeat (20 * BIT_CLKS) @(negedge clock);
    checks++; if (rxValid[0] !== 1'b0) begin errors++; $display("[TB] FAIL break_single: got %b expected 0", rxValid[0]); end
    lines[0] = 1'b1;
    repeat (2 * BIT_CLKS) @(negedge clock);
  endtask

  task automatic test_false_start;
    lines[0] = 1'b0;
    repeat (4) @(negedge clock);
    lines[0] = 1'b1;
    repeat (3 * BIT_CLKS) @(negedge clock);
    checks++; if (rxValid[0] !== 1'b0) begin errors++; $display("[TB] FAIL false_start: got %b expected 0", rxValid[0]); end
    sendFrame(0, 8'h55, evenBit(8'h55), 1'b1, 1'b1);
    checks++; if (rxData[0] !== 8'h55) begin errors++; $display("[TB] FAIL after_glitch_data: got %h expected 55", rxData[0]); end
    checks++; if ({rxValid[0], perr[0], ferr[0]} !== 3'b100) begin errors++; $display("[TB] FAIL after_glitch_flags: got %b expected 100", {rxValid[0], perr[0], ferr[0]}); end
    pulseReady(0);
  endtask

  task automatic test_back_to_back;
    sendFrame(0, 8'h11, evenBit(8'h11), 1'b1, 1'b1);
    sendFrame(0, 8'h22, evenBit(8'h22), 1'b1, 1'b1);
    checks++; if (rxData[0] !== 8'h11) begin errors++; $display("[TB] FAIL b2b_data: got %h expected 11", rxData[0]); end
    checks++; if ({rxValid[0], ovr[0]} !== 2'b11) begin errors++; $display("[TB] FAIL b2b_overrun: got %b expected 11", {rxValid[0], ovr[0]}); end
    pulseReady(0);
    checks++; if ({rxValid[0], ovr[0], rts[0]} !== 3'b001) begin errors++; $display("[TB] FAIL b2b_clear: got %b expected 001", {rxValid[0], ovr[0], rts[0]}); end
  endtask

  task automatic test_reset_midframe;
    sendFrame(0, 8'h5A, evenBit(8'h5A), 1'b1, 1'b1);
    checks++; if (rxValid[0] !== 1'b1) begin errors++; $display("[TB] FAIL pre_reset_valid: got %b expected 1", rxValid[0]); end
    driveBit(0, 1'b0);
    for (int i = 0; i < 4; i++) driveBit(0, 1'b1);
    lines[0] = 1'b0;
    repeat (BIT_CLKS / 2) @(negedge clock);
    reset = 1'b1;
    lines = 3'b111;
    repeat (2) @(negedge clock);
    checks++; if ({rxValid[0], perr[0], ferr[0], ovr[0], rts[0]} !== 5'b00001) begin errors++; $display("[TB] FAIL midreset_flags: got %b expected 00001", {rxValid[0], perr[0], ferr[0], ovr[0], rts[0]}); end
    checks++; if (rxData[0] !== 8'h00) begin errors++; $display("[TB] FAIL midreset_data: got %h expected 00", rxData[0]); end
    reset = 1'b0;
    repeat (2 * BIT_CLKS) @(negedge clock);
    sendFrame(0, 8'hF0, evenBit(8'hF0), 1'b1, 1'b1);
    checks++; if ({rxData[0], rxValid[0], perr[0], ferr[0]} !== {8'hF0, 3'b100}) begin errors++; $display("[TB] FAIL post_reset_frame: got %h/%b expected f0/100", rxData[0], {rxValid[0], perr[0], ferr[0]}); end
    pulseReady(0);
    sendFrame(2, 8'h96, evenBit(8'h96), 1'b1, 1'b0);
    checks++; if ({rxData[2], ferr[2]} !== {8'h96, 1'b1}) begin errors++; $display("[TB] FAIL stop2_err: got %h/%b expected 96/1", rxData[2], ferr[2]); end
    pulseReady(2);
    repeat (2 * BIT_CLKS) @(negedge clock);
    sendFrame(2, 8'h3A, evenBit(8'h3A), 1'b1, 1'b1);
    checks++; if ({rxData[2], rxValid[2], ferr[2]} !== {8'h3A, 2'b10}) begin errors++; $display("[TB] FAIL stop2_ok: got %h/%b expected 3a/10", rxData[2], {rxValid[2], ferr[2]}); end
    pulseReady(2);
  endtask

  // Model: one holding slot; a frame completing while the slot is full is dropped.
  task automatic test_random;
    logic       mValid, mPerr, mFerr, mOvr;
    logic [7:0] mData;
    mValid = 1'b0; mPerr = 1'b0; mFerr = 1'b0; mOvr = 1'b0; mData = 8'h00;
    for (int n = 0; n < 14; n++) begin
      logic [7:0] d;
      logic       p, stopOk;
      d      = 8'($urandom);
      p      = evenBit(d) ^ ($urandom_range(0, 3) == 0);
      stopOk = ($urandom_range(0, 4) != 0);
      sendFrame(0, d, p, stopOk, 1'b1);
      if (!mValid) begin
        mValid = 1'b1;
        mData  = d;
        mPerr  = (($countones(d) + int'(p)) % 2) != 0;
        mFerr  = !stopOk;
      end else begin
        mOvr = 1'b1;
      end
      checks++; if (rxData[0] !== mData) begin errors++; $display("[TB] FAIL rand_data[%0d]: got %h expected %h", n, rxData[0], mData); end
      checks++; if ({rxValid[0], perr[0], ferr[0], ovr[0]} !== {mValid, mPerr, mFerr, mOvr}) begin errors++; $display("[TB] FAIL rand_flags[%0d]: got %b expected %b", n, {rxValid[0], perr[0], ferr[0], ovr[0]}, {mValid, mPerr, mFerr, mOvr}); end
      if ($urandom_range(0, 2) != 0) begin
        pulseReady(0);
        mValid = 1'b0;
        mOvr   = 1'b0;
        checks++; if ({rxValid[0], ovr[0], rts[0]} !== 3'b001) begin errors++; $display("[TB] FAIL rand_accept[%0d]: got %b expected 001", n, {rxValid[0], ovr[0], rts[0]}); end
      end
      driveBit(0, 1'b1);
    end
    pulseReady(0);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_parity();
    test_frame_error();
    test_false_start();
    test_back_to_back();
    test_reset_midframe();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
